// File: rtl/count_display_scan_pkg.sv
// Shared constants for the front-panel counter display: counter indices,
// scan slot codes and the 7-segment glyph table.
package count_display_scan_pkg;

  localparam int unsigned NUM_COUNTERS = 8;
  localparam int unsigned STATE_W      = 4;
  localparam int unsigned BCD_W        = 12;
  localparam int unsigned SEG_W        = 8;

  localparam logic [3:0] CNT_C9_11 = 4'd0;
  localparam logic [3:0] CNT_C9_12 = 4'd1;
  localparam logic [3:0] CNT_C9_21 = 4'd2;
  localparam logic [3:0] CNT_C9_22 = 4'd3;
  localparam logic [3:0] CNT_C4_11 = 4'd4;
  localparam logic [3:0] CNT_C4_12 = 4'd5;
  localparam logic [3:0] CNT_C4_21 = 4'd6;
  localparam logic [3:0] CNT_C4_22 = 4'd7;

  localparam logic [1:0] SLOT_HUND = 2'd0;
  localparam logic [1:0] SLOT_TENS = 2'd1;
  localparam logic [1:0] SLOT_ONES = 2'd2;

  // {a,b,c,d,e,f,g,dp}; anything outside 0..9 goes dark
  function automatic logic [SEG_W-1:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_glyph = 8'hFC;
      4'd1:    seg_glyph = 8'h60;
      4'd2:    seg_glyph = 8'hDA;
      4'd3:    seg_glyph = 8'hF2;
      4'd4:    seg_glyph = 8'h66;
      4'd5:    seg_glyph = 8'hB6;
      4'd6:    seg_glyph = 8'hBE;
      4'd7:    seg_glyph = 8'hE0;
      4'd8:    seg_glyph = 8'hFE;
      4'd9:    seg_glyph = 8'hF6;
      default: seg_glyph = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/count_display_scan_bin8_to_bcd3.sv
// 8-bit binary to 3-digit BCD, double-dabble unrolled into combinational logic.
module bin8_to_bcd3
  import count_display_scan_pkg::*;
(
  input  logic [7:0]       bin_i,
  output logic [BCD_W-1:0] bcd_o
);

  logic [19:0] sh;

  always_comb begin
    sh = {12'd0, bin_i};
    for (int b = 0; b < 8; b++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = {sh[18:0], 1'b0};
    end
    bcd_o = sh[19:8];
  end

endmodule

// File: rtl/count_display_scan.sv
// Front-panel display path: BCD-converts eight counters, steps through them on
// each 1 Hz tick and scans the selected value across a 3-digit 7-seg display.
module count_display_scan
  import count_display_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic               clk_1000hz,
  input  logic               resetn,
  input  logic               clk_1hz,
  input  logic [7:0]         c9_11,
  input  logic [7:0]         c9_12,
  input  logic [7:0]         c9_21,
  input  logic [7:0]         c9_22,
  input  logic [7:0]         c4_11,
  input  logic [7:0]         c4_12,
  input  logic [7:0]         c4_21,
  input  logic [7:0]         c4_22,
  output logic [2:0]         digit,
  output logic [SEG_W-1:0]   seg_data,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] next_state,
  output logic [1:0]         i,
  output logic [BCD_W-1:0]   c9_11_d,
  output logic [BCD_W-1:0]   c9_12_d,
  output logic [BCD_W-1:0]   c9_21_d,
  output logic [BCD_W-1:0]   c9_22_d,
  output logic [BCD_W-1:0]   c4_11_d,
  output logic [BCD_W-1:0]   c4_12_d,
  output logic [BCD_W-1:0]   c4_21_d,
  output logic [BCD_W-1:0]   c4_22_d,
  output logic [3:0]         decoder_f_in,
  output logic [3:0]         decoder_s_in,
  output logic [3:0]         decoder_t_in
);

  localparam int unsigned          DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [7:0]         cnt_in [NUM_COUNTERS];
  logic [BCD_W-1:0]   bcd    [NUM_COUNTERS];

  logic               sync1_q, sync2_q, prev_q;
  logic [STATE_W-1:0] state_q, state_d, next_state_c;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         slot_q, slot_d;
  logic               tick_c, div_last_c;
  logic [BCD_W-1:0]   sel_bcd_c;
  logic [3:0]         nib_c;

  assign cnt_in[0] = c9_11;
  assign cnt_in[1] = c9_12;
  assign cnt_in[2] = c9_21;
  assign cnt_in[3] = c9_22;
  assign cnt_in[4] = c4_11;
  assign cnt_in[5] = c4_12;
  assign cnt_in[6] = c4_21;
  assign cnt_in[7] = c4_22;

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_bcd
    bin8_to_bcd3 u_bcd (
      .bin_i (cnt_in[g]),
      .bcd_o (bcd[g])
    );
  end

  assign c9_11_d = bcd[0];
  assign c9_12_d = bcd[1];
  assign c9_21_d = bcd[2];
  assign c9_22_d = bcd[3];
  assign c4_11_d = bcd[4];
  assign c4_12_d = bcd[5];
  assign c4_21_d = bcd[6];
  assign c4_22_d = bcd[7];

  // clk_1hz is only ever treated as data: two-flop sync plus edge detect
  always_ff @(posedge clk_1000hz or posedge resetn) begin
    if (resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= '0;
      div_q   <= '0;
      slot_q  <= '0;
    end else begin
      sync1_q <= clk_1hz;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
    end
  end

  // Counter selection and scan slot advance run independently of each other
  always_comb begin
    tick_c       = sync2_q & ~prev_q;
    next_state_c = (state_q >= CNT_C4_22) ? CNT_C9_11 : state_q + 4'd1;
    state_d      = tick_c ? next_state_c : state_q;
    div_last_c   = (div_q == DIV_LAST);
    div_d        = div_last_c ? '0 : div_q + DIV_W'(1);
    slot_d       = slot_q;
    if (div_last_c) begin
      slot_d = (slot_q >= SLOT_ONES) ? SLOT_HUND : slot_q + 2'd1;
    end
  end

  always_comb begin
    case (state_q)
      CNT_C9_11: sel_bcd_c = bcd[0];
      CNT_C9_12: sel_bcd_c = bcd[1];
      CNT_C9_21: sel_bcd_c = bcd[2];
      CNT_C9_22: sel_bcd_c = bcd[3];
      CNT_C4_11: sel_bcd_c = bcd[4];
      CNT_C4_12: sel_bcd_c = bcd[5];
      CNT_C4_21: sel_bcd_c = bcd[6];
      CNT_C4_22: sel_bcd_c = bcd[7];
      default:   sel_bcd_c = '0;
    endcase
  end

  assign decoder_f_in = sel_bcd_c[11:8];
  assign decoder_s_in = sel_bcd_c[7:4];
  assign decoder_t_in = sel_bcd_c[3:0];

  always_comb begin
    digit = 3'b000;
    nib_c = 4'hF;
    case (slot_q)
      SLOT_HUND: begin digit = 3'b100; nib_c = decoder_f_in; end
      SLOT_TENS: begin digit = 3'b010; nib_c = decoder_s_in; end
      SLOT_ONES: begin digit = 3'b001; nib_c = decoder_t_in; end
      default:   begin digit = 3'b000; nib_c = 4'hF; end
    endcase
    seg_data = seg_glyph(nib_c);
  end

  assign state      = state_q;
  assign next_state = next_state_c;
  assign i          = slot_q;

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan: two instances (SCAN_DIV 1 and 4) share
// stimulus; expectations go through a scoreboard queue and are checked by assertions.
module tb_count_display_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, clk_1hz;
  logic [7:0] cin [8];

  logic [2:0]  digit1, digit4;
  logic [7:0]  seg1, seg4;
  logic [3:0]  st1, st4, nst1, nst4;
  logic [1:0]  i1, i4;
  logic [11:0] bcd1 [8];
  logic [11:0] bcd4 [8];
  logic [3:0]  df1, ds1, dt1, df4, ds4, dt4;

  count_display_scan #(.SCAN_DIV(1)) dut1 (
    .clk_1000hz(clk), .resetn(resetn), .clk_1hz(clk_1hz),
    .c9_11(cin[0]), .c9_12(cin[1]), .c9_21(cin[2]), .c9_22(cin[3]),
    .c4_11(cin[4]), .c4_12(cin[5]), .c4_21(cin[6]), .c4_22(cin[7]),
    .digit(digit1), .seg_data(seg1), .state(st1), .next_state(nst1), .i(i1),
    .c9_11_d(bcd1[0]), .c9_12_d(bcd1[1]), .c9_21_d(bcd1[2]), .c9_22_d(bcd1[3]),
    .c4_11_d(bcd1[4]), .c4_12_d(bcd1[5]), .c4_21_d(bcd1[6]), .c4_22_d(bcd1[7]),
    .decoder_f_in(df1), .decoder_s_in(ds1), .decoder_t_in(dt1)
  );

  count_display_scan #(.SCAN_DIV(4)) dut4 (
    .clk_1000hz(clk), .resetn(resetn), .clk_1hz(clk_1hz),
    .c9_11(cin[0]), .c9_12(cin[1]), .c9_21(cin[2]), .c9_22(cin[3]),
    .c4_11(cin[4]), .c4_12(cin[5]), .c4_21(cin[6]), .c4_22(cin[7]),
    .digit(digit4), .seg_data(seg4), .state(st4), .next_state(nst4), .i(i4),
    .c9_11_d(bcd4[0]), .c9_12_d(bcd4[1]), .c9_21_d(bcd4[2]), .c9_22_d(bcd4[3]),
    .c4_11_d(bcd4[4]), .c4_12_d(bcd4[5]), .c4_21_d(bcd4[6]), .c4_22_d(bcd4[7]),
    .decoder_f_in(df4), .decoder_s_in(ds4), .decoder_t_in(dt4)
  );

  int checks   = 0;
  int failures = 0;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] glyph(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    return tbl[d];
  endfunction

  // raise clk_1hz, let the synchronised tick land, then drop it again
  task automatic pulse_1hz();
    clk_1hz = 1'b1;
    cycles(3);
    clk_1hz = 1'b0;
    cycles(3);
  endtask

  int exp_state;
  int vals [8];

  initial begin
    vals = '{1, 2, 4, 8, 16, 32, 64, 128};
    resetn  = 1'b1;
    clk_1hz = 1'b0;
    for (int k = 0; k < 8; k++) cin[k] = 8'(vals[k]);
    cycles(2);

    // Reset state and BCD conversion
    sb_push("rst_state", 32'd0);  sb_check(32'(st1));
    sb_push("rst_i", 32'd0);      sb_check(32'(i1));
    sb_push("rst_digit", 32'h4);  sb_check(32'(digit1));
    sb_push("rst_seg", 32'hFC);   sb_check(32'(seg1));
    for (int k = 0; k < 8; k++) begin
      sb_push($sformatf("bcd_%0d", k),
              32'(((vals[k] / 100) << 8) | (((vals[k] / 10) % 10) << 4) | (vals[k] % 10)));
      sb_check(32'(bcd1[k]));
    end
    cin[7] = 8'd255;
    #1;
    sb_push("bcd_255", 32'h255); sb_check(32'(bcd1[7]));
    cin[7] = 8'd128;
    cycles(1);

    // Scan with SCAN_DIV=1 and c9_11=1
    resetn = 1'b0;
    #1;
    sb_push("scan0_i", 32'd0);   sb_check(32'(i1));
    sb_push("scan0_dig", 32'h4); sb_check(32'(digit1));
    sb_push("scan0_seg", 32'hFC); sb_check(32'(seg1));
    cycles(1);
    sb_push("scan1_i", 32'd1);   sb_check(32'(i1));
    sb_push("scan1_dig", 32'h2); sb_check(32'(digit1));
    sb_push("scan1_seg", 32'hFC); sb_check(32'(seg1));
    cycles(1);
    sb_push("scan2_i", 32'd2);   sb_check(32'(i1));
    sb_push("scan2_dig", 32'h1); sb_check(32'(digit1));
    sb_push("scan2_seg", 32'h60); sb_check(32'(seg1));
    cycles(1);
    sb_push("scan3_i", 32'd0);   sb_check(32'(i1));

    // Eight 1 Hz edges: state walks 0..7 and wraps, 3 clocks after each edge
    exp_state = 0;
    for (int k = 0; k < 8; k++) begin
      clk_1hz = 1'b1;
      sb_push($sformatf("lat2_state_%0d", k), 32'(exp_state));
      cycles(2);
      sb_check(32'(st1));
      exp_state = (exp_state + 1) % 8;
      sb_push($sformatf("step_state_%0d", k), 32'(exp_state));
      sb_push($sformatf("step_next_%0d", k), 32'((exp_state + 1) % 8));
      sb_push($sformatf("step_state4_%0d", k), 32'(exp_state));
      cycles(1);
      sb_check(32'(st1));
      sb_check(32'(nst1));
      sb_check(32'(st4));
      if (exp_state == 7) begin
        sb_push("dec_f7", 32'd1); sb_check(32'(df1));
        sb_push("dec_s7", 32'd2); sb_check(32'(ds1));
        sb_push("dec_t7", 32'd8); sb_check(32'(dt1));
        sb_push("seg_sel7", 32'(i1 == 2'd0 ? glyph(1) : i1 == 2'd1 ? glyph(2) : glyph(8)));
        sb_check(32'(seg1));
      end
      clk_1hz = 1'b0;
      cycles(3);
    end

    // Async reset pulse while state=5, i=2
    for (int k = 0; k < 5; k++) pulse_1hz();
    for (int n = 0; n < 6 && i1 !== 2'd2; n++) @(negedge clk);
    sb_push("pre_rst_state", 32'd5); sb_check(32'(st1));
    sb_push("pre_rst_i", 32'd2);     sb_check(32'(i1));
    #1 resetn = 1'b1;
    #1;
    sb_push("async_state", 32'd0); sb_check(32'(st1));
    sb_push("async_i", 32'd0);     sb_check(32'(i1));
    sb_push("async_digit", 32'h4); sb_check(32'(digit1));
    resetn = 1'b0;
    #1 resetn = 1'b1;
    #1 resetn = 1'b0;
    cycles(5);
    sb_push("hold_state", 32'd0); sb_check(32'(st1));

    // clk_1hz high through reset release: exactly one advance; SCAN_DIV=4 phase
    cycles(1);
    clk_1hz = 1'b1;
    resetn  = 1'b1;
    #1 resetn = 1'b0;
    sb_push("rel_state", 32'd0); sb_check(32'(st1));
    sb_push("rel_i4", 32'd0);    sb_check(32'(i4));
    for (int n = 1; n <= 12; n++) begin
      cycles(1);
      sb_push($sformatf("hi_state_%0d", n), 32'(n >= 3 ? 1 : 0));
      sb_check(32'(st1));
      sb_push($sformatf("div4_i_%0d", n), 32'((n / 4) % 3));
      sb_check(32'(i4));
    end
    sb_push("div4_state", 32'd1); sb_check(32'(st4));
    cycles(10);
    sb_push("steady_state", 32'd1); sb_check(32'(st1));

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
